// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and constants for the writeback / CDB path.
// Requester indices fix the writeback source order seen by cdb_arbiter.
package uarch_pkg;

  localparam int PIPE_WIDTH = 2;
  localparam int TAG_WIDTH  = 6;
  localparam int XLEN       = 32;

  localparam int CDB_NUM_REQ  = 4;
  localparam int CDB_REQ_ALU0 = 0;
  localparam int CDB_REQ_ALU1 = 1;
  localparam int CDB_REQ_MDU  = 2;
  localparam int CDB_REQ_DMEM = 3;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [XLEN-1:0]      data;
    logic                 exc;
  } writeback_packet_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational picker: selects up to NUM_PICK set bits of mask, scanning
// circularly from ptr; pick k holds the k-th set bit found.
module cdb_rr_picker
  import uarch_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_PICK = 2,
  parameter int PTR_W    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]              mask,
  input  logic [PTR_W-1:0]                ptr,
  output logic [NUM_PICK-1:0]             pick_val,
  output logic [NUM_PICK-1:0][PTR_W-1:0]  pick_idx
);

  localparam logic [PTR_W:0] REQ_LIM = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;
  int               found;

  always_comb begin
    pick_val = '0;
    pick_idx = '0;
    scan_sum = '0;
    scan_idx = '0;
    found    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_sum = {1'b0, ptr} + off[PTR_W:0];
      if (scan_sum >= REQ_LIM) begin
        scan_sum = scan_sum - REQ_LIM;
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (mask[scan_idx]) begin
        // Constant-indexed slot match keeps the outputs free of variable selects.
        for (int k = 0; k < NUM_PICK; k++) begin
          if (found == k) begin
            pick_val[k] = 1'b1;
            pick_idx[k] = scan_idx;
          end
        end
        found = found + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to NUM_PORTS writeback requesters per
// cycle, round-robin from rr_ptr, and registers the winners onto the CDB.
// Optional starvation promotion is compiled in with `define CDB_ARB_STARVE_EN.
module cdb_arbiter
  import uarch_pkg::*;
#(
  parameter int NUM_REQ      = CDB_NUM_REQ,
  parameter int NUM_PORTS    = PIPE_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_REQ-1:0]                  req_val,
  input  writeback_packet_t [NUM_REQ-1:0]     req_packet,
  output logic [NUM_REQ-1:0]                  req_gnt,
  output logic [NUM_PORTS-1:0]                cdb_val,
  output writeback_packet_t [NUM_PORTS-1:0]   cdb_ports
);

  localparam int PTR_W = idx_width(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;

  logic [NUM_REQ-1:0]                rr_mask;
  logic [NUM_PORTS-1:0]              rr_pick_val;
  logic [NUM_PORTS-1:0][PTR_W-1:0]   rr_pick_idx;

  // Final port assignment; sel_rr marks picks that came from the round-robin pass.
  logic [NUM_PORTS-1:0]              sel_val;
  logic [NUM_PORTS-1:0][PTR_W-1:0]   sel_idx;
  logic [NUM_PORTS-1:0]              sel_rr;

  logic [NUM_PORTS-1:0]              cdb_val_reg, cdb_val_next;
  writeback_packet_t [NUM_PORTS-1:0] cdb_ports_reg, cdb_ports_next;

`ifdef CDB_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [NUM_REQ-1:0][CNT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [NUM_REQ-1:0]                starved_mask;
  logic [NUM_PORTS-1:0]              st_pick_val;
  logic [NUM_PORTS-1:0][PTR_W-1:0]   st_pick_idx;
  int                                num_starved;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_wait
      assign starved_mask[gi]  = req_val[gi] && (wait_cnt_reg[gi] == CNT_MAX);
      assign wait_cnt_next[gi] = (flush || !req_val[gi] || req_gnt[gi]) ? '0 :
                                 (wait_cnt_reg[gi] == CNT_MAX) ? CNT_MAX :
                                 wait_cnt_reg[gi] + 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Starved requesters are served lowest index first, hence the fixed zero pointer.
  cdb_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .NUM_PICK (NUM_PORTS),
    .PTR_W    (PTR_W)
  ) u_starve_pick (
    .mask     (starved_mask),
    .ptr      ('0),
    .pick_val (st_pick_val),
    .pick_idx (st_pick_idx)
  );

  assign rr_mask = req_val & ~starved_mask;
`else
  assign rr_mask = req_val;
`endif

  cdb_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .NUM_PICK (NUM_PORTS),
    .PTR_W    (PTR_W)
  ) u_rr_pick (
    .mask     (rr_mask),
    .ptr      (rr_ptr_reg),
    .pick_val (rr_pick_val),
    .pick_idx (rr_pick_idx)
  );

  always_comb begin
    sel_val = '0;
    sel_idx = '0;
    sel_rr  = '0;
`ifdef CDB_ARB_STARVE_EN
    num_starved = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (st_pick_val[k]) num_starved = num_starved + 1;
    end
    // Round-robin picks fill whatever ports the starved requesters left free.
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (k < num_starved) begin
        sel_val[k] = 1'b1;
        sel_idx[k] = st_pick_idx[k];
      end else begin
        for (int j = 0; j < NUM_PORTS; j++) begin
          if ((j == k - num_starved) && rr_pick_val[j]) begin
            sel_val[k] = 1'b1;
            sel_idx[k] = rr_pick_idx[j];
            sel_rr[k]  = 1'b1;
          end
        end
      end
    end
`else
    sel_val = rr_pick_val;
    sel_idx = rr_pick_idx;
    sel_rr  = rr_pick_val;
`endif
    if (rst || flush) begin
      sel_val = '0;
      sel_rr  = '0;
    end
  end

  always_comb begin
    req_gnt = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel_val[k]) req_gnt[sel_idx[k]] = 1'b1;
    end
  end

  // The last round-robin winner in port order sets where the next scan begins.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel_val[k] && sel_rr[k]) begin
        rr_ptr_next = (sel_idx[k] == LAST_IDX) ? '0 : sel_idx[k] + 1'b1;
      end
    end
  end

  genvar pi;
  generate
    for (pi = 0; pi < NUM_PORTS; pi++) begin : g_port
      assign cdb_val_next[pi]   = sel_val[pi];
      assign cdb_ports_next[pi] = sel_val[pi] ? req_packet[sel_idx[pi]] : '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      cdb_val_reg   <= '0;
      cdb_ports_reg <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      cdb_val_reg   <= cdb_val_next;
      cdb_ports_reg <= cdb_ports_next;
    end
  end

  assign cdb_val   = cdb_val_reg;
  assign cdb_ports = cdb_ports_reg;

endmodule
